// File: rtl/hilo_muldiv_ctrl_pkg.sv
// HI/LO multiply/divide sequencer shared types.
// Op encodings, FSM states and widths.
package hilo_muldiv_ctrl_pkg;

  localparam int WORD_LEN = 32;
  localparam int HLOP_LEN = 3;

  typedef enum logic [HLOP_LEN-1:0] {
    HLOP_MULT  = 3'd0,
    HLOP_MULTU = 3'd1,
    HLOP_DIV   = 3'd2,
    HLOP_DIVU  = 3'd3,
    HLOP_MTHI  = 3'd4,
    HLOP_MTLO  = 3'd5
  } hlop_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } hl_state_e;

endpackage

// File: rtl/hilo_muldiv_ctrl_iter_dp.sv
// One shift-add multiply or restoring divide step per enable.
// Ports: clock, reset, load/step, is_div, a/b operands, acc/low regs.
module hilo_iter_dp #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         step,
  input  logic         is_div,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] acc,
  output logic [W-1:0] low
);

  logic [W-1:0] opd;
  logic [W:0]   add_s;
  logic [W:0]   shl;
  logic [W:0]   sub_s;
  logic [W-1:0] acc_n;
  logic [W-1:0] low_n;

  // mul: {acc,low} = {partial, multiplier}, shifted right
  // div: acc = remainder, low = dividend/quotient, shifted left
  always_comb begin
    add_s = {1'b0, acc} + {1'b0, (low[0] ? opd : '0)};
    shl   = {acc, low[W-1]};
    sub_s = shl - {1'b0, opd};
    acc_n = add_s[W:1];
    low_n = {add_s[0], low[W-1:1]};
    if (is_div) begin
      if (!sub_s[W]) begin
        acc_n = sub_s[W-1:0];
        low_n = {low[W-2:0], 1'b1};
      end else begin
        acc_n = shl[W-1:0];
        low_n = {low[W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc <= '0;
      low <= '0;
      opd <= '0;
    end else if (load) begin
      acc <= '0;
      low <= a;
      opd <= b;
    end else if (step) begin
      acc <= acc_n;
      low <= low_n;
    end
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner: sequences MULT/DIV ops, MT writes and EXE stall.
// Ports: start/op/val1/val2 in, flush, rd_hilo; busy/stall/done/hi/lo out.
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int W     = WORD_LEN,
  parameter int CNT_W = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [HLOP_LEN-1:0] op,
  input  logic [W-1:0]        val1,
  input  logic [W-1:0]        val2,
  input  logic                flush,
  input  logic                rd_hilo,
  output logic                busy,
  output logic                stall,
  output logic                done,
  output logic [W-1:0]        hi,
  output logic [W-1:0]        lo
);

  hl_state_e    state;
  logic [CNT_W-1:0] cnt;
  logic         is_div;
  logic         neg_q;
  logic         neg_r;
  logic         dz;

  logic         op_sgn;
  logic         op_div;
  logic         op_md;
  logic         accept;
  logic         load;
  logic         step;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic [W-1:0] acc;
  logic [W-1:0] low;
  logic [2*W-1:0] prod;
  logic [2*W-1:0] prod_c;
  logic [W-1:0] q_c;
  logic [W-1:0] r_c;

  assign op_sgn = (op == HLOP_MULT) | (op == HLOP_DIV);
  assign op_div = (op == HLOP_DIV) | (op == HLOP_DIVU);
  assign op_md  = op_sgn | op_div | (op == HLOP_MULTU);

  assign busy   = (state != ST_IDLE);
  assign stall  = busy & (start | rd_hilo);
  assign accept = (state == ST_IDLE) & start & ~flush;
  assign load   = accept & op_md;
  assign step   = (state == ST_RUN) & ~flush;

  // Signed ops iterate on magnitudes; signs are restored in FIX.
  assign opa = (op_sgn && val1[W-1]) ? -val1 : val1;
  assign opb = (op_sgn && val2[W-1]) ? -val2 : val2;

  always_comb begin
    prod   = {acc, low};
    prod_c = neg_q ? -prod : prod;
    q_c    = neg_q ? -low : low;
    r_c    = neg_r ? -acc : acc;
    // x/0 leaves |x| in the remainder, so only LO needs forcing.
    if (dz) q_c = '1;
  end

  hilo_iter_dp #(.W(W)) u_dp (
    .clock  (clock),
    .reset  (reset),
    .load   (load),
    .step   (step),
    .is_div (is_div),
    .a      (opa),
    .b      (opb),
    .acc    (acc),
    .low    (low)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            unique case (1'b1)
              op_md: begin
                state  <= ST_RUN;
                cnt    <= '0;
                is_div <= op_div;
                neg_q  <= op_sgn & (val1[W-1] ^ val2[W-1]);
                neg_r  <= op_sgn & val1[W-1];
                dz     <= op_div & ~|val2;
              end
              (op == HLOP_MTHI): hi <= val1;
              (op == HLOP_MTLO): lo <= val1;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          if (flush) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(W - 1)) state <= ST_FIX;
          end
        end
        ST_FIX: begin
          state <= ST_IDLE;
          if (!flush) begin
            done <= 1'b1;
            if (is_div) begin
              hi <= r_c;
              lo <= q_c;
            end else begin
              hi <= prod_c[2*W-1:W];
              lo <= prod_c[W-1:0];
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl.
// Vector table plus stall, flush and async-reset sequences.
module tb_hilo_muldiv_ctrl;
  import hilo_muldiv_ctrl_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] val1 = '0;
  logic [31:0] val2 = '0;
  logic        flush = 1'b0;
  logic        rd_hilo = 1'b0;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       nm;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  vec_t vecs[10];

  hilo_muldiv_ctrl dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .val1    (val1),
    .val2    (val2),
    .flush   (flush),
    .rd_hilo (rd_hilo),
    .busy    (busy),
    .stall   (stall),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run_op(input string nm, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el);
    int n;
    @(negedge clock);
    start = 1'b1; op = o; val1 = a; val2 = b;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clock);
    end
    chk({nm, " busy cycles"}, n, 33);
    chk({nm, " done"}, {31'b0, done}, 1);
    chk({nm, " hi"}, hi, eh);
    chk({nm, " lo"}, lo, el);
    @(negedge clock);
    chk({nm, " done drop"}, {31'b0, done}, 0);
  endtask

  initial begin
    int n;
    bit ok;
    bit saw;

    vecs[0] = '{"mult 7*-3", HLOP_MULT, 32'd7, 32'hFFFFFFFD,
                32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1] = '{"multu max*max", HLOP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
                32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{"divu 100/0", HLOP_DIVU, 32'd100, 32'd0,
                32'd100, 32'hFFFFFFFF};
    vecs[3] = '{"div -7/2", HLOP_DIV, 32'hFFFFFFF9, 32'd2,
                32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4] = '{"div ovf", HLOP_DIV, 32'h80000000, 32'hFFFFFFFF,
                32'h0, 32'h80000000};
    vecs[5] = '{"div -7/0", HLOP_DIV, 32'hFFFFFFF9, 32'd0,
                32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[6] = '{"divu 100/7", HLOP_DIVU, 32'd100, 32'd7,
                32'd2, 32'd14};
    vecs[7] = '{"mult min*min", HLOP_MULT, 32'h80000000, 32'h80000000,
                32'h40000000, 32'h0};
    vecs[8] = '{"mult -1*1", HLOP_MULT, 32'hFFFFFFFF, 32'd1,
                32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[9] = '{"div 7/-2", HLOP_DIV, 32'd7, 32'hFFFFFFFE,
                32'd1, 32'hFFFFFFFD};

    repeat (2) @(negedge clock);
    chk("rst hi", hi, 0);
    chk("rst lo", lo, 0);
    chk("rst busy", {31'b0, busy}, 0);
    chk("rst done", {31'b0, done}, 0);
    chk("rst stall", {31'b0, stall}, 0);
    reset = 1'b1;

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].nm, vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].eh, vecs[i].el);

    // rd_hilo during a MULT holds stall until the done cycle
    @(negedge clock);
    start = 1'b1; op = HLOP_MULT; val1 = 32'd5; val2 = 32'd6;
    @(negedge clock);
    start = 1'b0;
    #1 chk("stall idle-rd none", {31'b0, stall}, 0);
    repeat (3) @(negedge clock);
    rd_hilo = 1'b1;
    ok = 1'b1;
    n = 0;
    while (busy && n < 40) begin
      #1 if (!stall) ok = 1'b0;
      n++;
      @(negedge clock);
    end
    chk("stall held", {31'b0, ok}, 1);
    chk("stall busy end", {31'b0, busy}, 0);
    #1;
    chk("stall drop", {31'b0, stall}, 0);
    chk("stall done", {31'b0, done}, 1);
    chk("stall lo", lo, 32'd30);
    chk("stall hi", hi, 32'd0);
    rd_hilo = 1'b0;

    // start presented while busy is stalled, not taken
    @(negedge clock);
    start = 1'b1; op = HLOP_MULT; val1 = 32'd2; val2 = 32'd3;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    start = 1'b1; op = HLOP_MTLO; val1 = 32'hDEAD;
    #1 chk("busy start stall", {31'b0, stall}, 1);
    @(negedge clock);
    start = 1'b0;
    chk("busy mt ignored", lo, 32'd30);
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clock);
    end
    chk("busy mult lo", lo, 32'd6);

    // MT writes in IDLE
    @(negedge clock);
    start = 1'b1; op = HLOP_MTHI; val1 = 32'h1234;
    @(negedge clock);
    start = 1'b0;
    chk("mthi hi", hi, 32'h1234);
    chk("mthi busy", {31'b0, busy}, 0);
    chk("mthi done", {31'b0, done}, 0);
    start = 1'b1; op = HLOP_MTLO; val1 = 32'h55;
    @(negedge clock);
    start = 1'b0;
    chk("mtlo lo", lo, 32'h55);

    // flush kills an in-flight DIV
    start = 1'b1; op = HLOP_DIV; val1 = 32'd50; val2 = 32'd5;
    @(negedge clock);
    start = 1'b0;
    repeat (8) @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    chk("flush busy", {31'b0, busy}, 0);
    saw = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (done) saw = 1'b1;
    end
    chk("flush no done", {31'b0, saw}, 0);
    chk("flush hi", hi, 32'h1234);
    chk("flush lo", lo, 32'h55);

    // flush beats start in IDLE
    start = 1'b1; flush = 1'b1; op = HLOP_MTHI; val1 = 32'h999;
    @(negedge clock);
    start = 1'b0; flush = 1'b0;
    chk("flush+start hi", hi, 32'h1234);
    chk("flush+start busy", {31'b0, busy}, 0);

    // async reset mid-MULT
    start = 1'b1; op = HLOP_MULT; val1 = 32'h10000; val2 = 32'h10000;
    @(negedge clock);
    start = 1'b0;
    repeat (14) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("arst hi", hi, 0);
    chk("arst lo", lo, 0);
    chk("arst busy", {31'b0, busy}, 0);
    @(negedge clock);
    reset = 1'b1;
    run_op("mult 3*4", HLOP_MULT, 32'd3, 32'd4, 32'd0, 32'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
Multi-cycle sequencer for MULT/MULTU/DIV/DIVU/MTHI/MTLO in the EXE stage. It owns the architectural HI/LO registers and iterates a 32-step shift-add multiply or restoring divide. It raises a stall to the hazard unit while a read of HI/LO (MFHI/MFLO) or a new HI/LO op collides with an in-flight operation. hi/lo feed the EXE_MFHI/EXE_MFLO result mux.

Parameters:
W, 32, operand/HI/LO width (equals `WORD_LEN)
CNT_W, 5, iteration counter width, log2(W)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  EXE holds a HI/LO-writing op this cycle
op  in  3  HLOP_MULT/MULTU/DIV/DIVU/MTHI/MTLO
val1  in  W  rs operand (multiplicand / dividend / MT source)
val2  in  W  rt operand (multiplier / divisor)
flush  in  1  kill in-flight op (branch/exception flush)
rd_hilo  in  1  EXE holds MFHI or MFLO this cycle
busy  out  1  iteration in progress
stall  out  1  freeze IF/ID/EXE this cycle
done  out  1  one-cycle pulse, HI/LO just updated by mul/div
hi  out  W  HI register
lo  out  W  LO register

Behaviour:
- Reset (reset low, async): state=IDLE, cnt=0, hi=0, lo=0, busy=0, done=0; stall=0. An op in flight is discarded.
- States: IDLE, RUN, FIX. busy = (state != IDLE).
- IDLE, start & !flush at edge E0:
  - mul/div op: latch |val1|,|val2| (signed ops) or raw (unsigned), record the result signs (product sign = s1^s2; quotient sign = s1^s2; remainder sign = s1). Set cnt=0, go to RUN.
  - MTHI/MTLO: write hi/lo = val1 at E0, stay IDLE, no done.
- RUN: one iteration per edge, E1..E32.
  - Multiply: 64-bit {acc,mplr} shift-add.
  - Divide: restoring shift-subtract.
  - At cnt==W-1, go to FIX.
- FIX (edge E33):
  - Apply two's-complement sign correction.
  - Write hi/lo: mul gives HI=upper, LO=lower; div gives LO=quotient, HI=remainder.
  - Pulse done in the cycle after E33; go to IDLE.
- Latency: busy high for 33 cycles; the new hi/lo is visible the cycle after E33.
- stall = busy & (start | rd_hilo), combinational. A stalled start is held upstream and re-presented; it is never queued internally.
- start while busy: not accepted (stall covers it).
- rd_hilo while IDLE: no stall, so forwarding of a same-cycle MT write is not required. The hazard unit orders MT then MF.
- Divisor zero: HI=dividend (val1 unmodified), LO=all ones, both signed and unsigned, still 33 cycles.
- Signed overflow (0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0.
- flush in RUN/FIX: go to IDLE next edge, hi/lo unchanged, no done. flush & start in IDLE: flush wins, nothing written.
- hi/lo update only at FIX or on an MT write; they are stable otherwise.

Decomposition:
- Shared constants in defines.v: HLOP_* encodings (3 bits), `HLOP_LEN, state encodings for IDLE/RUN/FIX.
- One natural sub-module, hilo_iter_dp: holds the acc/operand shift registers and performs one mul or div step per enable. It is combinational next-step logic plus registers, and has no FSM.
- The controller keeps the FSM, counter, sign bookkeeping, HI/LO and stall.

Test Plan:
- MULT val1=7, val2=0xFFFFFFFD -> busy for 33 cycles, done pulse, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU 0xFFFFFFFF * 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. DIVU 100/0 -> HI=100, LO=0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start MULT, then rd_hilo=1 from cycle 5 -> stall=1 through the last busy cycle; stall drops the cycle done pulses, and hi/lo then hold the new product.
- MTHI 0x1234 in IDLE -> hi=0x1234 next cycle, no busy/done. Then start DIV with flush at cycle 10 -> IDLE, hi still 0x1234, no done.
- Assert reset low at cycle 15 of a MULT -> hi=lo=0, busy=0 immediately (async). After release, a new MULT 3*4 gives LO=12, HI=0.
